valve_position_monitor: RTL and testbench

- Parametrised successor to the per-board diaphragm-valve feedback logic.
- Accepts a stream of tagged ADC samples (channel index + count) from an upstream I2C/ADC sequencer.
- Maintains a debounced, hysteretic OPEN/CLOSED state per channel against programmable close limits.
- Flags channels whose samples go stale, and reports a registered pattern-match (e.g. dialyzer bypass) to the driver/serial layers.

---
 rtl/vpm_pkg.sv | 30 +++
 rtl/vpm_channel.sv | 110 +++++++++++
 rtl/valve_position_monitor.sv | 78 +++++++
 tb/tb_valve_position_monitor.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpm_pkg.sv
// Shared types and helpers for the valve position monitor.
package vpm_pkg;

    typedef enum logic [1:0] {
        CLS_OPEN  = 2'd0,
        CLS_BAND  = 2'd1,
        CLS_CLOSE = 2'd2
    } cls_t;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_OPEN    = 2'd1,
        ST_CLOSED  = 2'd2
    } ch_st_t;

    localparam int unsigned DEB_W   = 4;
    localparam int unsigned STALE_W = 8;

    // a - b clamped at zero, result masked to the given width
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned width);
        logic [31:0] d;
        d = (a > b) ? (a - b) : 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (32'(i) >= width) d[i] = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/vpm_channel.sv
// One valve channel: thresholds, debounce state machine, stale timer, sense register.
module vpm_channel
    import vpm_pkg::*;
#(
    parameter int unsigned ADC_W        = 10,
    parameter int unsigned MARGIN       = 32,
    parameter int unsigned HYST         = 8,
    parameter int unsigned DEB_N        = 4,
    parameter int unsigned STALE_FRAMES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             smp,
    input  logic [ADC_W-1:0] data,
    input  logic             strb_frame,
    input  logic             strb_load,
    input  logic [ADC_W-1:0] close_val,
    output logic [ADC_W-1:0] sense,
    output logic             closed,
    output logic             st_valid,
    output logic             stale,
    output logic             flip_c
);

    logic [ADC_W-1:0]   close_thr, open_thr, close_thr_new_c, open_thr_new_c;
    ch_st_t             state, state_nxt_c;
    cls_t               cand, cand_nxt_c, cls_c;
    logic [DEB_W-1:0]   deb, deb_nxt_c;
    logic [STALE_W-1:0] stale_cnt, stale_cnt_nxt_c;
    logic               stale_nxt_c;

    // Classification, debounce decision and stale counter next values
    always_comb begin
        close_thr_new_c = ADC_W'(sat_sub(32'(close_val), 32'(MARGIN), ADC_W));
        open_thr_new_c  = ADC_W'(sat_sub(32'(close_thr_new_c), 32'(HYST), ADC_W));

        if (data >= close_thr)    cls_c = CLS_CLOSE;
        else if (data < open_thr) cls_c = CLS_OPEN;
        else                      cls_c = CLS_BAND;

        state_nxt_c = state;
        cand_nxt_c  = cand;
        deb_nxt_c   = deb;
        if (smp) begin
            unique case (state)
                ST_UNKNOWN: begin
                    if (cls_c == CLS_BAND) begin
                        deb_nxt_c = '0;
                    end else if (cls_c == cand) begin
                        deb_nxt_c = DEB_W'(deb + DEB_W'(1));
                    end else begin
                        cand_nxt_c = cls_c;
                        deb_nxt_c  = DEB_W'(1);
                    end
                end
                ST_OPEN:   deb_nxt_c = (cls_c == CLS_CLOSE) ? DEB_W'(deb + DEB_W'(1)) : '0;
                ST_CLOSED: deb_nxt_c = (cls_c == CLS_OPEN)  ? DEB_W'(deb + DEB_W'(1)) : '0;
                default:   deb_nxt_c = '0;
            endcase
            if (deb_nxt_c == DEB_W'(DEB_N)) begin
                deb_nxt_c = '0;
                if (state == ST_UNKNOWN)
                    state_nxt_c = (cand_nxt_c == CLS_CLOSE) ? ST_CLOSED : ST_OPEN;
                else
                    state_nxt_c = (state == ST_OPEN) ? ST_CLOSED : ST_OPEN;
            end
        end

        // an accepted sample clears the timer even if a frame strobe coincides
        stale_cnt_nxt_c = stale_cnt;
        if (smp)
            stale_cnt_nxt_c = '0;
        else if (enable && strb_frame && (stale_cnt != {STALE_W{1'b1}}))
            stale_cnt_nxt_c = STALE_W'(stale_cnt + STALE_W'(1));
        stale_nxt_c = (stale_cnt_nxt_c >= STALE_W'(STALE_FRAMES));

        flip_c = (state_nxt_c == ST_CLOSED) != (state == ST_CLOSED);
    end

    // Channel state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            close_thr <= '0;
            open_thr  <= '0;
            state     <= ST_UNKNOWN;
            cand      <= CLS_OPEN;
            deb       <= '0;
            stale_cnt <= '0;
            sense     <= '0;
            closed    <= 1'b0;
            st_valid  <= 1'b0;
            stale     <= 1'b0;
        end else begin
            if (strb_load) begin
                close_thr <= close_thr_new_c;
                open_thr  <= open_thr_new_c;
            end
            if (smp) sense <= data;
            state     <= state_nxt_c;
            cand      <= cand_nxt_c;
            deb       <= deb_nxt_c;
            stale_cnt <= stale_cnt_nxt_c;
            stale     <= stale_nxt_c;
            closed    <= (state_nxt_c == ST_CLOSED);
            st_valid  <= (state_nxt_c != ST_UNKNOWN) && !stale_nxt_c;
        end
    end

endmodule

// File: rtl/valve_position_monitor.sv
// Multi-channel valve position monitor: sample routing, change/error strobes, pattern match.
module valve_position_monitor
    import vpm_pkg::*;
#(
    parameter int unsigned     NCH          = 6,
    parameter int unsigned     ADC_W        = 10,
    parameter int unsigned     MARGIN       = 32,
    parameter int unsigned     HYST         = 8,
    parameter int unsigned     DEB_N        = 4,
    parameter int unsigned     STALE_FRAMES = 8,
    parameter logic [NCH-1:0]  MATCH_DEF    = 6'b101010,
    localparam int unsigned    CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 strb_frame,
    input  logic                 strb_load,
    input  logic [NCH*ADC_W-1:0] close_val,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [CH_W-1:0]      s_ch,
    input  logic [ADC_W-1:0]     s_data,
    output logic [NCH*ADC_W-1:0] sense_out,
    output logic [NCH-1:0]       valve_states,
    output logic [NCH-1:0]       state_valid,
    output logic [NCH-1:0]       stale_fault,
    output logic                 chg_strb,
    output logic                 ch_err_strb,
    output logic                 match_state
);

    logic           acc_c;
    logic           ch_ok_c;
    logic [NCH-1:0] flip_c;

    assign s_ready = enable;
    assign acc_c   = s_valid && enable;
    assign ch_ok_c = (32'(s_ch) < NCH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        vpm_channel #(
            .ADC_W       (ADC_W),
            .MARGIN      (MARGIN),
            .HYST        (HYST),
            .DEB_N       (DEB_N),
            .STALE_FRAMES(STALE_FRAMES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .smp       (acc_c && (32'(s_ch) == 32'(i))),
            .data      (s_data),
            .strb_frame(strb_frame),
            .strb_load (strb_load),
            .close_val (close_val[i*ADC_W +: ADC_W]),
            .sense     (sense_out[i*ADC_W +: ADC_W]),
            .closed    (valve_states[i]),
            .st_valid  (state_valid[i]),
            .stale     (stale_fault[i]),
            .flip_c    (flip_c[i])
        );
    end

    // Change/error strobes and pattern match, one cycle behind their sources
    always_ff @(posedge clk) begin
        if (reset) begin
            chg_strb    <= 1'b0;
            ch_err_strb <= 1'b0;
            match_state <= 1'b0;
        end else begin
            chg_strb    <= |flip_c;
            ch_err_strb <= acc_c && !ch_ok_c;
            match_state <= (valve_states == MATCH_DEF) && (&state_valid) && !(|stale_fault);
        end
    end

endmodule

// File: tb/tb_valve_position_monitor.sv
// Self-checking bench for valve_position_monitor with a history-based reference model.
module tb_valve_position_monitor;

    localparam int NCH = 6;
    localparam int ADC_W = 10;
    localparam int MARGIN = 32;
    localparam int HYST = 8;
    localparam int DEB_N = 4;
    localparam int STALE = 8;
    localparam logic [NCH-1:0] MATCH = 6'b101010;

    logic                 clk = 1'b0;
    logic                 reset, enable, strb_frame, strb_load, s_valid;
    logic [NCH*ADC_W-1:0] close_val;
    logic                 s_ready;
    logic [2:0]           s_ch;
    logic [ADC_W-1:0]     s_data;
    logic [NCH*ADC_W-1:0] sense_out;
    logic [NCH-1:0]       valve_states, state_valid, stale_fault;
    logic                 chg_strb, ch_err_strb, match_state;

    int tests = 0;
    int fails = 0;

    valve_position_monitor #(
        .NCH(NCH), .ADC_W(ADC_W), .MARGIN(MARGIN), .HYST(HYST),
        .DEB_N(DEB_N), .STALE_FRAMES(STALE), .MATCH_DEF(MATCH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .strb_frame(strb_frame),
        .strb_load(strb_load), .close_val(close_val), .s_valid(s_valid),
        .s_ready(s_ready), .s_ch(s_ch), .s_data(s_data), .sense_out(sense_out),
        .valve_states(valve_states), .state_valid(state_valid),
        .stale_fault(stale_fault), .chg_strb(chg_strb),
        .ch_err_strb(ch_err_strb), .match_state(match_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // states: 0 unknown, 1 open, 2 closed; classes: 0 open, 1 band, 2 close
    int m_state [NCH];
    int m_cthr  [NCH];
    int m_othr  [NCH];
    int m_cnt   [NCH];
    int m_sense [NCH];
    int hist    [NCH][$];
    logic [NCH-1:0] m_closed, m_valid, m_stale;
    logic m_chg, m_err, m_match;

    task automatic model_step();
        logic [NCH-1:0] old_closed;
        int cls, n, tgt, cv;
        bit all_same, want, hit;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_state[c] = 0; m_cthr[c] = 0; m_othr[c] = 0;
                m_cnt[c] = 0; m_sense[c] = 0; hist[c].delete();
            end
            m_closed = '0; m_valid = '0; m_stale = '0;
            m_chg = 0; m_err = 0; m_match = 0;
            return;
        end
        old_closed = m_closed;
        m_match = (m_closed == MATCH) && (&m_valid) && !(|m_stale);
        m_err = s_valid && enable && (int'(s_ch) >= NCH);
        for (int c = 0; c < NCH; c++) begin
            hit = s_valid && enable && (int'(s_ch) == c);
            if (hit) begin
                cls = (int'(s_data) >= m_cthr[c]) ? 2 : (int'(s_data) < m_othr[c]) ? 0 : 1;
                m_sense[c] = int'(s_data);
                hist[c].push_back(cls);
                if (hist[c].size() > 40) void'(hist[c].pop_front());
                n = hist[c].size();
                if (n >= DEB_N) begin
                    tgt = hist[c][n-1];
                    all_same = 1;
                    for (int k = 0; k < DEB_N; k++)
                        if (hist[c][n-1-k] != tgt) all_same = 0;
                    if (m_state[c] == 0)      want = (tgt != 1);
                    else if (m_state[c] == 1) want = (tgt == 2);
                    else                      want = (tgt == 0);
                    if (all_same && want) begin
                        m_state[c] = (tgt == 2) ? 2 : 1;
                        hist[c].delete();
                    end
                end
                m_cnt[c] = 0;
            end else if (enable && strb_frame && m_cnt[c] < 255) begin
                m_cnt[c]++;
            end
            m_stale[c]  = (m_cnt[c] >= STALE);
            m_closed[c] = (m_state[c] == 2);
            m_valid[c]  = (m_state[c] != 0) && !m_stale[c];
            if (strb_load) begin
                cv = int'(close_val[c*ADC_W +: ADC_W]);
                m_cthr[c] = (cv > MARGIN) ? cv - MARGIN : 0;
                m_othr[c] = (m_cthr[c] > HYST) ? m_cthr[c] - HYST : 0;
            end
        end
        m_chg = (m_closed != old_closed);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int ch, input int d);
        s_valid = 1; s_ch = 3'(ch); s_data = ADC_W'(d);
        tick();
        s_valid = 0;
    endtask

    task automatic load_all(input int v);
        for (int c = 0; c < NCH; c++) close_val[c*ADC_W +: ADC_W] = ADC_W'(v);
        strb_load = 1;
        tick();
        strb_load = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1; tick(); tick();
        reset = 0;
        tests++;
        if ({sense_out, valve_states, state_valid, stale_fault, chg_strb, ch_err_strb, match_state} !== '0) begin
            fails++; $display("FAIL reset_outputs: got vs=%b sv=%b sf=%b chg=%b err=%b m=%b, want all 0",
                              valve_states, state_valid, stale_fault, chg_strb, ch_err_strb, match_state);
        end
    endtask

    task automatic test_close_basic();
        load_all(500);
        for (int k = 0; k < 4; k++) begin
            sample(0, 470);
            tests++;
            if ({valve_states[0], state_valid[0], chg_strb} !== ((k == 3) ? 3'b111 : 3'b000)) begin
                fails++; $display("FAIL close_basic[%0d]: got vs/sv/chg=%b%b%b want %b", k,
                                  valve_states[0], state_valid[0], chg_strb, (k == 3) ? 3'b111 : 3'b000);
            end
        end
        tick();
        tests++;
        if (chg_strb !== 1'b0) begin fails++; $display("FAIL close_chg_once: got %b want 0", chg_strb); end
    endtask

    task automatic test_hysteresis();
        int seq1 [4] = '{462, 465, 462, 465};
        int seq2 [8] = '{459, 459, 459, 462, 459, 459, 459, 459};
        for (int k = 0; k < 4; k++) begin
            sample(0, seq1[k]);
            tests++;
            if (valve_states[0] !== 1'b1) begin
                fails++; $display("FAIL hyst_band[%0d]: got %b want 1", k, valve_states[0]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            sample(0, seq2[k]);
            tests++;
            if ({valve_states[0], chg_strb} !== ((k == 7) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL hyst_open[%0d]: got vs/chg=%b%b want %b", k,
                                  valve_states[0], chg_strb, (k == 7) ? 2'b01 : 2'b10);
            end
        end
        tests++;
        if (state_valid[0] !== 1'b1) begin fails++; $display("FAIL hyst_valid: got %b want 1", state_valid[0]); end
    endtask

    task automatic test_saturation();
        close_val[1*ADC_W +: ADC_W] = 10'd10;
        strb_load = 1; tick(); strb_load = 0;
        for (int k = 0; k < 8; k++) begin
            sample(1, 0);
            tests++;
            if (valve_states[1] !== ((k >= 3) ? 1'b1 : 1'b0)) begin
                fails++; $display("FAIL saturation[%0d]: got %b want %b", k, valve_states[1], k >= 3);
            end
        end
    endtask

    task automatic test_stale();
        for (int k = 0; k < 4; k++) sample(2, 470);
        strb_frame = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            tests++;
            if ({stale_fault[2], state_valid[2], valve_states[2]} !== ((k == 7) ? 3'b101 : 3'b011)) begin
                fails++; $display("FAIL stale_frames[%0d]: got sf/sv/vs=%b%b%b want %b", k,
                                  stale_fault[2], state_valid[2], valve_states[2], (k == 7) ? 3'b101 : 3'b011);
            end
        end
        strb_frame = 0;
        tick();
        tests++;
        if (match_state !== 1'b0) begin fails++; $display("FAIL stale_match: got %b want 0", match_state); end
        strb_frame = 1;
        sample(2, 470);
        tests++;
        if ({stale_fault[2], state_valid[2]} !== 2'b01) begin
            fails++; $display("FAIL stale_clear: got sf/sv=%b%b want 01", stale_fault[2], state_valid[2]);
        end
        for (int k = 0; k < 7; k++) tick();
        strb_frame = 0;
        tests++;
        if (stale_fault[2] !== 1'b0) begin fails++; $display("FAIL stale_restart: got %b want 0", stale_fault[2]); end
        sample(2, 470);
    endtask

    task automatic test_invalid_ch();
        sample(7, 123);
        tests++;
        if (ch_err_strb !== 1'b1) begin fails++; $display("FAIL ch_err_7: got %b want 1", ch_err_strb); end
        tests++;
        if (sense_out[0 +: ADC_W] !== 10'd459 || sense_out[2*ADC_W +: ADC_W] !== 10'd470) begin
            fails++; $display("FAIL ch_err_sense: got ch0=%0d ch2=%0d want 459 470",
                              sense_out[0 +: ADC_W], sense_out[2*ADC_W +: ADC_W]);
        end
        sample(6, 55);
        tests++;
        if (ch_err_strb !== 1'b1) begin fails++; $display("FAIL ch_err_6: got %b want 1", ch_err_strb); end
        tick();
        tests++;
        if (ch_err_strb !== 1'b0) begin fails++; $display("FAIL ch_err_pulse: got %b want 0", ch_err_strb); end
    endtask

    task automatic test_disable();
        enable = 0;
        strb_frame = 1;
        for (int k = 0; k < 10; k++) sample(0, 600);
        strb_frame = 0;
        tests++;
        if (s_ready !== 1'b0) begin fails++; $display("FAIL dis_ready: got %b want 0", s_ready); end
        tests++;
        if (sense_out[0 +: ADC_W] !== 10'd459 || valve_states[0] !== 1'b0) begin
            fails++; $display("FAIL dis_hold: got sense=%0d vs=%b want 459 0",
                              sense_out[0 +: ADC_W], valve_states[0]);
        end
        tests++;
        if (stale_fault[2] !== 1'b0) begin fails++; $display("FAIL dis_stale: got %b want 0", stale_fault[2]); end
        enable = 1;
    endtask

    task automatic test_bypass();
        reset = 1; tick(); reset = 0;
        load_all(500);
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < NCH; c++)
                sample(c, MATCH[c] ? 470 : 400);
        tests++;
        if ({valve_states, state_valid, match_state} !== {MATCH, 6'h3f, 1'b0}) begin
            fails++; $display("FAIL bypass_settle: got vs=%b sv=%b m=%b want %b 111111 0",
                              valve_states, state_valid, match_state, MATCH);
        end
        tick();
        tests++;
        if (match_state !== 1'b1) begin fails++; $display("FAIL bypass_match: got %b want 1", match_state); end
        sample(1, 400);
        sample(1, 400);
        reset = 1; tick(); reset = 0;
        tests++;
        if ({sense_out, valve_states, state_valid, stale_fault, chg_strb, ch_err_strb, match_state} !== '0) begin
            fails++; $display("FAIL bypass_reset: got vs=%b sv=%b m=%b want all 0",
                              valve_states, state_valid, match_state);
        end
    endtask

    task automatic test_random();
        logic [NCH*ADC_W-1:0] exp_sense;
        int c, d;
        for (int c2 = 0; c2 < NCH; c2++)
            close_val[c2*ADC_W +: ADC_W] = ADC_W'($urandom_range(0, 1023));
        strb_load = 1; tick(); strb_load = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            c = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 1023));
            else d = ((c < NCH) ? m_cthr[c] : 500) + int'($urandom_range(0, 40)) - 20;
            if (d < 0) d = 0;
            if (d > 1023) d = 1023;
            s_valid    = ($urandom_range(0, 3) != 0);
            s_ch       = 3'(c);
            s_data     = ADC_W'(d);
            enable     = ($urandom_range(0, 15) != 0);
            strb_frame = ($urandom_range(0, 5) == 0);
            strb_load  = ($urandom_range(0, 49) == 0);
            if (strb_load)
                for (int c2 = 0; c2 < NCH; c2++)
                    close_val[c2*ADC_W +: ADC_W] = ADC_W'($urandom_range(0, 1023));
            tick();
            for (int c2 = 0; c2 < NCH; c2++) exp_sense[c2*ADC_W +: ADC_W] = ADC_W'(m_sense[c2]);
            tests++;
            if (sense_out !== exp_sense) begin
                fails++; $display("FAIL rnd_sense@%0d: got %h want %h", cyc, sense_out, exp_sense);
            end
            tests++;
            if ({valve_states, state_valid, stale_fault} !== {m_closed, m_valid, m_stale}) begin
                fails++; $display("FAIL rnd_state@%0d: got vs=%b sv=%b sf=%b want vs=%b sv=%b sf=%b",
                                  cyc, valve_states, state_valid, stale_fault, m_closed, m_valid, m_stale);
            end
            tests++;
            if ({chg_strb, ch_err_strb, match_state} !== {m_chg, m_err, m_match}) begin
                fails++; $display("FAIL rnd_strb@%0d: got chg/err/m=%b%b%b want %b%b%b",
                                  cyc, chg_strb, ch_err_strb, match_state, m_chg, m_err, m_match);
            end
        end
        s_valid = 0; strb_frame = 0; strb_load = 0; enable = 1;
    endtask

    initial begin
        reset = 1; enable = 1; strb_frame = 0; strb_load = 0; s_valid = 0;
        s_ch = '0; s_data = '0; close_val = '0;
        #1;
        test_reset();
        test_close_basic();
        test_hysteresis();
        test_saturation();
        test_stale();
        test_invalid_ch();
        test_disable();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
